// File: rtl/tcdm_bank_responder_if.sv
// TCDM request/response bundle for MP ports; the accelerator side takes the master
// modport and the memory responder takes the slave modport.
interface tcdm_bank_responder_if #(
   parameter int MP = 4
);
   logic [MP-1:0]        req;
   logic [MP-1:0]        gnt;
   logic [MP-1:0][31:0]  add;
   logic [MP-1:0]        wen;
   logic [MP-1:0][3:0]   be;
   logic [MP-1:0][31:0]  data;
   logic [MP-1:0][31:0]  r_data;
   logic [MP-1:0]        r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );
endinterface

// File: rtl/tcdm_bank_responder.sv
// Word-interleaved multi-port TCDM responder: per-bank round-robin arbitration,
// byte-masked writes and registered one-cycle-latency responses.
module tcdm_bank_responder #(
   parameter int MP         = 4,
   parameter int NB         = 8,
   parameter int BANK_WORDS = 256
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [MP-1:0] stall_i,
   tcdm_bank_responder_if.slave tcdm
);

   localparam int LNB = $clog2(NB);
   localparam int LBW = $clog2(BANK_WORDS);
   localparam int PW  = (MP > 1) ? $clog2(MP) : 1;

   typedef logic [LNB-1:0] bank_t;
   typedef logic [LBW-1:0] row_t;
   typedef logic [PW-1:0]  port_t;

   bank_t                 bank_sel [MP];
   row_t                  row_sel  [MP];
   logic [NB-1:0][MP-1:0] cand;
   logic [NB-1:0]         hit;
   port_t                 win      [NB];
   port_t                 rr_ptr   [NB];
   logic [MP-1:0]         gnt;
   logic [31:0]           mem      [NB][BANK_WORDS];
   logic                  unused_add;

   // Step a port index forward by off (< MP), wrapping modulo MP.
   function automatic port_t rr_idx(input port_t base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= MP) s = s - MP;
      return port_t'(s);
   endfunction

   // Low byte-offset bits and aliased upper bits do not take part in decode.
   assign unused_add = ^tcdm.add;

   always_comb begin
      for (int p = 0; p < MP; p++) begin
         bank_sel[p] = tcdm.add[p][2 +: LNB];
         row_sel[p]  = tcdm.add[p][2 + LNB +: LBW];
      end
   end

   always_comb begin
      cand = '0;
      for (int b = 0; b < NB; b++) begin
         for (int p = 0; p < MP; p++) begin
            cand[b][p] = !rst_i && tcdm.req[p] && !stall_i[p] &&
                         (bank_sel[p] == bank_t'(b));
         end
      end
   end

   // NOTE: every always_comb output gets a default before any conditional
   // assignment, so no path leaves a variable unassigned and no latch appears.
   always_comb begin
      hit = '0;
      for (int b = 0; b < NB; b++) win[b] = '0;
      for (int b = 0; b < NB; b++) begin
         for (int i = 0; i < MP; i++) begin
            if (!hit[b] && cand[b][rr_idx(rr_ptr[b], i)]) begin
               hit[b] = 1'b1;
               win[b] = rr_idx(rr_ptr[b], i);
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      for (int p = 0; p < MP; p++) begin
         gnt[p] = hit[bank_sel[p]] && (win[bank_sel[p]] == port_t'(p));
      end
   end

   assign tcdm.gnt = gnt;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int b = 0; b < NB; b++) rr_ptr[b] <= '0;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (hit[b]) rr_ptr[b] <= rr_idx(win[b], 1);
         end
      end
   end

   // NOTE: the storage array has no reset; clearing it would cost a write port
   // per word and masters must write before they read anyway. Reset cycles
   // cannot write because arbitration is suppressed while rst_i is high.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (hit[b] && !tcdm.wen[win[b]]) begin
            for (int i = 0; i < 4; i++) begin
               if (tcdm.be[win[b]][i]) begin
                  mem[b][row_sel[win[b]]][8*i +: 8] <= tcdm.data[win[b]][8*i +: 8];
               end
            end
         end
      end
   end

   // A bank never sees a read and a write in the same cycle, so the read
   // below always returns the contents left by earlier cycles.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tcdm.r_valid <= '0;
         tcdm.r_data  <= '0;
      end else begin
         for (int p = 0; p < MP; p++) begin
            tcdm.r_valid[p] <= gnt[p];
            tcdm.r_data[p]  <= (gnt[p] && tcdm.wen[p]) ? mem[bank_sel[p]][row_sel[p]] : 32'h0;
         end
      end
   end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder: stimulus tasks push expected responses,
// a negedge monitor pops and compares them against every r_valid pulse.
module tb_tcdm_bank_responder;

   localparam int MP    = 4;
   localparam int BOUND = 30;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic          clk_i;
   logic          rst_i;
   logic [MP-1:0] stall_i;
   int            cyc;
   int            n_vec;
   int            n_miss;
   exp_t          sb [MP][$];
   exp_t          e;
   int            gnt_log  [$];
   int            gcyc_log [$];
   int            g;
   int            pc [MP];

   tcdm_bank_responder_if #(.MP(MP)) tcdm ();

   tcdm_bank_responder #(.MP(MP), .NB(8), .BANK_WORDS(256)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .tcdm    (tcdm)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every response pulse must match the oldest expectation for its port.
   always @(negedge clk_i) begin
      for (int p = 0; p < MP; p++) begin
         if (tcdm.r_valid[p] !== 1'b0) begin
            if (sb[p].size() == 0) begin
               n_vec++;
               n_miss++;
               $display("FAIL unexpected_rvalid p%0d: got r_valid=%b, required 0 (cycle %0d)",
                        p, tcdm.r_valid[p], cyc);
            end else begin
               e = sb[p].pop_front();
               check($sformatf("rsp_data_p%0d", p), tcdm.r_data[p], e.data);
               check($sformatf("rsp_cycle_p%0d", p), 32'(cyc), 32'(e.due));
            end
         end
      end
   end

   // Called just after a rising edge; returns just after the edge that accepts it.
   task automatic do_req(input int p, input logic [31:0] addr, input logic wen,
                         input logic [3:0] be, input logic [31:0] data,
                         input logic [31:0] exp_data, output int gcyc);
      bit got;
      got = 1'b0;
      gcyc = -1;
      tcdm.req[p]  = 1'b1;
      tcdm.add[p]  = addr;
      tcdm.wen[p]  = wen;
      tcdm.be[p]   = be;
      tcdm.data[p] = data;
      for (int n = 0; n < BOUND; n++) begin
         @(negedge clk_i);
         if (tcdm.gnt[p] === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         n_vec++;
         n_miss++;
         $display("FAIL gnt_timeout p%0d: no grant within %0d cycles for addr %h", p, BOUND, addr);
         tcdm.req[p] = 1'b0;
      end else begin
         gcyc = cyc;
         gnt_log.push_back(p);
         gcyc_log.push_back(cyc);
         sb[p].push_back('{data: (wen ? exp_data : 32'h0), due: cyc + 1});
         @(posedge clk_i);
         #1;
         tcdm.req[p] = 1'b0;
      end
   endtask

   task automatic two_reads(input int p);
      int gc;
      do_req(p, 32'h20, 1'b1, 4'h0, 32'h0, 32'hCAFE_0020, gc);
      do_req(p, 32'h20, 1'b1, 4'h0, 32'h0, 32'hCAFE_0020, gc);
   endtask

   initial begin
      n_vec   = 0;
      n_miss  = 0;
      rst_i   = 1'b1;
      stall_i = '0;
      tcdm.req  = '0;
      tcdm.wen  = '1;
      tcdm.add  = '0;
      tcdm.be   = '0;
      tcdm.data = '0;

      // Reset with every port requesting a write to banks 4..7.
      for (int p = 0; p < MP; p++) begin
         tcdm.req[p]  = 1'b1;
         tcdm.wen[p]  = 1'b0;
         tcdm.add[p]  = 32'h10 + 32'(4 * p);
         tcdm.be[p]   = 4'hF;
         tcdm.data[p] = 32'hA000_0000 + 32'(p);
      end
      repeat (3) begin
         @(negedge clk_i);
         check("rst_gnt", 32'(tcdm.gnt), 32'h0);
         check("rst_rvalid", 32'(tcdm.r_valid), 32'h0);
         check("rst_rdata", tcdm.r_data[0] | tcdm.r_data[1] | tcdm.r_data[2] | tcdm.r_data[3], 32'h0);
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("release_gnt", 32'(tcdm.gnt), 32'hF);
      for (int p = 0; p < MP; p++) begin
         if (tcdm.gnt[p] === 1'b1) sb[p].push_back('{data: 32'h0, due: cyc + 1});
      end
      @(posedge clk_i);
      #1 tcdm.req = '0;

      // Write then read back-to-back on port 0.
      do_req(0, 32'h10, 1'b0, 4'hF, 32'hDEAD_BEEF, 32'h0, g);
      do_req(0, 32'h10, 1'b1, 4'h0, 32'h0, 32'hDEAD_BEEF, g);

      // Byte-enable merge.
      do_req(0, 32'h44, 1'b0, 4'hF, 32'h1122_3344, 32'h0, g);
      do_req(0, 32'h44, 1'b0, 4'h5, 32'hAABB_CCDD, 32'h0, g);
      do_req(0, 32'h44, 1'b1, 4'h0, 32'h0, 32'h11BB_33DD, g);

      // Bank conflict: port 3 seeds 0x20 (leaving bank 0's pointer at 0), then all contend.
      do_req(3, 32'h20, 1'b0, 4'hF, 32'hCAFE_0020, 32'h0, g);
      gnt_log.delete();
      gcyc_log.delete();
      fork
         two_reads(0);
         two_reads(1);
         two_reads(2);
         two_reads(3);
      join
      check("rr_count", 32'(gnt_log.size()), 32'd8);
      for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
         check($sformatf("rr_order_%0d", i), 32'(gnt_log[i]), 32'(i % 4));
         if (i > 0) check($sformatf("rr_cycle_%0d", i), 32'(gcyc_log[i] - gcyc_log[0]), 32'(i));
      end

      // Distinct banks all granted together, then an aliased read.
      fork
         do_req(0, 32'h0, 1'b0, 4'hF, 32'h5000_0000, 32'h0, pc[0]);
         do_req(1, 32'h4, 1'b0, 4'hF, 32'h5000_0001, 32'h0, pc[1]);
         do_req(2, 32'h8, 1'b0, 4'hF, 32'h5000_0002, 32'h0, pc[2]);
         do_req(3, 32'hC, 1'b0, 4'hF, 32'h5000_0003, 32'h0, pc[3]);
      join
      for (int p = 1; p < MP; p++) check($sformatf("parallel_cycle_p%0d", p), 32'(pc[p]), 32'(pc[0]));
      do_req(1, 32'h2000, 1'b1, 4'h0, 32'h0, 32'h5000_0000, g);
      do_req(2, 32'h8, 1'b1, 4'h0, 32'h0, 32'h5000_0002, g);

      // Stall holds off port 1 for three cycles.
      stall_i[1] = 1'b1;
      fork
         do_req(1, 32'h14, 1'b1, 4'h0, 32'h0, 32'hA000_0001, g);
         begin
            repeat (3) begin
               @(negedge clk_i);
               check("stall_gnt", 32'(tcdm.gnt[1]), 32'h0);
            end
            @(posedge clk_i);
            #1 stall_i[1] = 1'b0;
         end
      join

      // Reset right after a granted write; a write requested during reset is ignored.
      do_req(2, 32'h18, 1'b0, 4'hF, 32'h7777_7777, 32'h0, g);
      rst_i        = 1'b1;
      tcdm.req[2]  = 1'b1;
      tcdm.wen[2]  = 1'b0;
      tcdm.add[2]  = 32'h1C;
      tcdm.be[2]   = 4'hF;
      tcdm.data[2] = 32'h9999_9999;
      @(negedge clk_i);
      check("midrst_gnt", 32'(tcdm.gnt), 32'h0);
      @(negedge clk_i);
      check("midrst_rvalid", 32'(tcdm.r_valid), 32'h0);
      check("midrst_rdata", tcdm.r_data[2], 32'h0);
      @(posedge clk_i);
      #1;
      rst_i       = 1'b0;
      tcdm.req[2] = 1'b0;
      @(negedge clk_i);
      check("post_rst_rvalid", 32'(tcdm.r_valid), 32'h0);
      @(posedge clk_i);
      #1;
      do_req(0, 32'h18, 1'b1, 4'h0, 32'h0, 32'h7777_7777, g);
      do_req(0, 32'h1C, 1'b1, 4'h0, 32'h0, 32'hA000_0003, g);

      repeat (3) @(posedge clk_i);
      #1;
      for (int p = 0; p < MP; p++) check($sformatf("sb_drain_p%0d", p), 32'(sb[p].size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL sim_timeout: bench did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
